fc_layer_sched: RTL and testbench

- Sequencer for one fully-connected layer built on the shared MAC datapath (fc_front: 64-bit weight × 64-bit fm word per cycle, accumulator with clear).
- For each output neuron: clears the MAC, streams WORDS fm/weight address pairs, then captures the accumulated result.
- Requantizes each result to int8 and keeps a running argmax; reports the winning class once per layer.
- Sits between the NICE command decoder (start/base addresses) and the fm/weight SRAM read ports.

---
 rtl/fc_pkg.sv | 28 ++
 rtl/fc_rd_delay.sv | 33 +++
 rtl/fc_layer_sched.sv | 177 +++++++++++++++++
 tb/tb_fc_layer_sched.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared types, widths and int8 requantize helper for the FC layer sequencer
package fc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_WAIT_RES,
    S_COMPARE,
    S_DONE
  } state_t;

  localparam int DEF_ACC_W  = 21;
  localparam int DEF_ADDR_W = 16;

  localparam logic signed [7:0] INT8_MIN = -8'sd128;
  localparam logic signed [7:0] INT8_MAX = 8'sd127;

  // Arithmetic shift then clamp into the int8 range; input must be sign-extended to 32 bits.
  function automatic logic signed [7:0] sat8(input logic signed [31:0] v, input int unsigned sh);
    logic signed [31:0] s;
    s = v >>> sh;
    if (s > 32'sd127)       return INT8_MAX;
    else if (s < -32'sd128) return INT8_MIN;
    else                    return s[7:0];
  endfunction

endpackage

// File: rtl/fc_rd_delay.sv
// rtl/fc_rd_delay.sv - RD_LAT-stage delay line carrying the read strobe and last-word tag
module fc_rd_delay #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic last,
  output logic en_d,
  output logic last_d
);

  logic [RD_LAT-1:0] en_sr;
  logic [RD_LAT-1:0] last_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_sr   <= '0;
      last_sr <= '0;
    end else begin
      en_sr[0]   <= en;
      last_sr[0] <= last;
      for (int i = 1; i < RD_LAT; i++) begin
        en_sr[i]   <= en_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
    end
  end

  assign en_d   = en_sr[RD_LAT-1];
  assign last_d = last_sr[RD_LAT-1];

endmodule

// File: rtl/fc_layer_sched.sv
// rtl/fc_layer_sched.sv - FC layer sequencer: MAC address streaming, int8 requantize, argmax
// Optional macro FC_SCORE_OUT_EN adds per-neuron score outputs (o_score_valid/o_score_idx/o_score).
module fc_layer_sched
  import fc_pkg::*;
#(
  parameter int N_OUT  = 10,
  parameter int WORDS  = 48,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int SHIFT  = 4,
  parameter int RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic [ADDR_W-1:0]       i_fm_base_addr,
  input  logic [ADDR_W-1:0]       i_wt_base_addr,
  output logic                    o_busy,
  output logic                    o_rd_en,
  output logic [ADDR_W-1:0]       o_fm_addr,
  output logic [ADDR_W-1:0]       o_wt_addr,
  output logic                    o_mac_clr,
  output logic                    o_mac_en,
  output logic                    o_mac_last,
  input  logic                    i_mac_valid,
  input  logic signed [ACC_W-1:0] i_mac_result,
  output logic                    o_done,
  output logic                    o_class_valid,
  output logic [7:0]              o_class_idx,
  output logic [7:0]              o_class_val
`ifdef FC_SCORE_OUT_EN
  ,
  output logic                    o_score_valid,
  output logic [7:0]              o_score_idx,
  output logic [7:0]              o_score
`endif
);

  localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t             state;
  logic [ADDR_W-1:0]  fm_base;
  logic [ADDR_W-1:0]  wt_ptr;
  logic [WORD_W-1:0]  word;
  logic [7:0]         neuron;
  logic [7:0]         best_idx;
  logic signed [7:0]  best_val;
  logic signed [7:0]  q_reg;
  logic               rd_last;

  logic signed [31:0] res_ext;
  logic signed [7:0]  q_in;
  logic               improve;
  logic [ADDR_W-1:0]  next_off;

  always_comb begin
    res_ext  = 32'(i_mac_result);
    q_in     = sat8(res_ext, SHIFT);
    improve  = (q_reg > best_val);
    next_off = ADDR_W'(word) + ADDR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      fm_base       <= '0;
      wt_ptr        <= '0;
      word          <= '0;
      neuron        <= '0;
      best_idx      <= '0;
      best_val      <= INT8_MIN;
      q_reg         <= '0;
      rd_last       <= 1'b0;
      o_busy        <= 1'b0;
      o_rd_en       <= 1'b0;
      o_fm_addr     <= '0;
      o_wt_addr     <= '0;
      o_mac_clr     <= 1'b0;
      o_done        <= 1'b0;
      o_class_valid <= 1'b0;
      o_class_idx   <= '0;
      o_class_val   <= '0;
`ifdef FC_SCORE_OUT_EN
      o_score_valid <= 1'b0;
      o_score_idx   <= '0;
      o_score       <= '0;
`endif
    end else begin
      o_mac_clr <= 1'b0;
      o_rd_en   <= 1'b0;
      rd_last   <= 1'b0;
      o_done    <= 1'b0;
`ifdef FC_SCORE_OUT_EN
      o_score_valid <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (i_start) begin
            fm_base       <= i_fm_base_addr;
            wt_ptr        <= i_wt_base_addr;
            neuron        <= '0;
            best_idx      <= '0;
            best_val      <= INT8_MIN;
            o_class_valid <= 1'b0;
            o_busy        <= 1'b1;
            o_mac_clr     <= 1'b1;
            state         <= S_CLEAR;
          end
        end
        // Outputs are registered, so the first read is launched here to land in the first ISSUE cycle.
        S_CLEAR: begin
          word      <= '0;
          o_rd_en   <= 1'b1;
          o_fm_addr <= fm_base;
          o_wt_addr <= wt_ptr;
          rd_last   <= (WORDS == 1);
          state     <= S_ISSUE;
        end
        S_ISSUE: begin
          if (word == WORD_W'(WORDS - 1)) begin
            wt_ptr <= wt_ptr + ADDR_W'(WORDS);
            state  <= S_WAIT_RES;
          end else begin
            word      <= word + WORD_W'(1);
            o_rd_en   <= 1'b1;
            o_fm_addr <= fm_base + next_off;
            o_wt_addr <= wt_ptr + next_off;
            rd_last   <= (word == WORD_W'(WORDS - 2));
          end
        end
        S_WAIT_RES: begin
          if (i_mac_valid) begin
            q_reg <= q_in;
            state <= S_COMPARE;
`ifdef FC_SCORE_OUT_EN
            o_score_valid <= 1'b1;
            o_score_idx   <= neuron;
            o_score       <= q_in;
`endif
          end
        end
        S_COMPARE: begin
          if (improve) begin
            best_val <= q_reg;
            best_idx <= neuron;
          end
          if (neuron == 8'(N_OUT - 1)) begin
            o_done        <= 1'b1;
            o_class_valid <= 1'b1;
            o_class_idx   <= improve ? neuron : best_idx;
            o_class_val   <= improve ? q_reg : best_val;
            state         <= S_DONE;
          end else begin
            neuron    <= neuron + 8'd1;
            o_mac_clr <= 1'b1;
            state     <= S_CLEAR;
          end
        end
        S_DONE: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  fc_rd_delay #(.RD_LAT(RD_LAT)) u_rd_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (o_rd_en),
    .last   (rd_last),
    .en_d   (o_mac_en),
    .last_d (o_mac_last)
  );

endmodule

// File: tb/tb_fc_layer_sched.sv
// tb/tb_fc_layer_sched.sv - scoreboard bench for fc_layer_sched, RD_LAT=1 and RD_LAT=3 lanes
module tb_fc_layer_sched;

  localparam int N_OUT = 3;
  localparam int WORDS = 4;
  localparam int SHIFT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [15:0] fm_base = '0;
  logic [15:0] wt_base = '0;

  logic        busy[2], rd_en[2], mac_clr[2], mac_en[2], mac_last[2], done[2], cls_valid[2], mac_valid[2];
  logic [15:0] fm_addr[2], wt_addr[2];
  logic [7:0]  cls_idx[2], cls_val[2];
  logic signed [20:0] mac_res[2];
`ifdef FC_SCORE_OUT_EN
  logic        sc_v[2];
  logic [7:0]  sc_i[2], sc_q[2];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fc_layer_sched #(
      .N_OUT(N_OUT), .WORDS(WORDS), .ADDR_W(16), .ACC_W(21), .SHIFT(SHIFT), .RD_LAT((g == 0) ? 1 : 3)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .i_start(start),
      .i_fm_base_addr(fm_base), .i_wt_base_addr(wt_base),
      .o_busy(busy[g]), .o_rd_en(rd_en[g]), .o_fm_addr(fm_addr[g]), .o_wt_addr(wt_addr[g]),
      .o_mac_clr(mac_clr[g]), .o_mac_en(mac_en[g]), .o_mac_last(mac_last[g]),
      .i_mac_valid(mac_valid[g]), .i_mac_result(mac_res[g]),
      .o_done(done[g]), .o_class_valid(cls_valid[g]), .o_class_idx(cls_idx[g]), .o_class_val(cls_val[g])
`ifdef FC_SCORE_OUT_EN
      , .o_score_valid(sc_v[g]), .o_score_idx(sc_i[g]), .o_score(sc_q[g])
`endif
    );
  end

  int checks = 0;
  int fails = 0;
  logic [31:0] exp_rd[$];
  int rd_ptr[2], en_cnt[2], clr_cnt[2], last_cnt[2], done_cnt[2], pend[2], mac_k[2];
  bit cls_pend[2];
  logic [3:0] hist[2];
  int exp_idx, exp_val;
  int res[N_OUT];

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int lat(input int l);
    return (l == 0) ? 1 : 3;
  endfunction

  // Reference requantizer: floor division by 2^SHIFT, then clamp to int8.
  function automatic int quant(input int r);
    int d, q;
    d = 1 << SHIFT;
    q = (r >= 0) ? r / d : -((-r + d - 1) / d);
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return q;
  endfunction

  function automatic int rand_res();
    logic [31:0] u;
    logic signed [20:0] t;
    u = $urandom;
    t = u[20:0];
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 8000)) - 4000;
    return int'(t);
  endfunction

  function automatic logic [54:0] outs(input int l);
    return {busy[l], rd_en[l], mac_clr[l], mac_en[l], mac_last[l], done[l], cls_valid[l],
            fm_addr[l], wt_addr[l], cls_idx[l], cls_val[l]};
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
        if (!rst_n) begin
          hist[l] = '0; en_cnt[l] = 0; pend[l] = 0; mac_k[l] = 0;
          mac_valid[l] = 1'b0; cls_pend[l] = 1'b0;
          continue;
        end
        mac_valid[l] = 1'b0;
        if (pend[l] > 0) begin
          pend[l]--;
          if (pend[l] == 0) begin
            mac_valid[l] = 1'b1;
            mac_res[l] = res[mac_k[l] % N_OUT][20:0];
            mac_k[l]++;
          end
        end
        if (mac_en[l] || hist[l][lat(l)-1])
          chk(mac_en[l] == hist[l][lat(l)-1], "mac_en_lag", mac_en[l], hist[l][lat(l)-1]);
        hist[l] = {hist[l][2:0], rd_en[l]};
        if (mac_en[l]) begin
          chk(mac_last[l] == ((en_cnt[l] % WORDS) == WORDS - 1), "mac_last_align",
              mac_last[l], (en_cnt[l] % WORDS) == WORDS - 1);
          en_cnt[l]++;
        end
        if (mac_last[l]) begin
          last_cnt[l]++;
          pend[l] = 2;
        end
        if (mac_clr[l]) clr_cnt[l]++;
        if (rd_en[l]) begin
          chk(rd_ptr[l] < exp_rd.size(), "rd_extra", rd_ptr[l], exp_rd.size());
          if (rd_ptr[l] < exp_rd.size())
            chk({fm_addr[l], wt_addr[l]} == exp_rd[rd_ptr[l]], "rd_addr",
                {fm_addr[l], wt_addr[l]}, exp_rd[rd_ptr[l]]);
          rd_ptr[l]++;
        end
        if (done[l]) begin
          chk(cls_pend[l], "unexpected_done", done_cnt[l], l);
          if (cls_pend[l]) begin
            chk(cls_idx[l] == exp_idx, "class_idx", cls_idx[l], exp_idx);
            chk($signed(cls_val[l]) == exp_val, "class_val", $signed(cls_val[l]), exp_val);
            chk(cls_valid[l] && busy[l], "done_flags", {cls_valid[l], busy[l]}, 3);
            chk(rd_ptr[l] == exp_rd.size(), "rd_count", rd_ptr[l], exp_rd.size());
            chk(clr_cnt[l] == N_OUT, "clr_count", clr_cnt[l], N_OUT);
            chk(last_cnt[l] == N_OUT, "last_count", last_cnt[l], N_OUT);
          end
          cls_pend[l] = 1'b0;
          done_cnt[l]++;
        end
      end
    end
  endtask

  task automatic prep_layer(input logic [15:0] fb, input logic [15:0] wb);
    int bi, bq, q;
    exp_rd.delete();
    for (int n = 0; n < N_OUT; n++)
      for (int w = 0; w < WORDS; w++)
        exp_rd.push_back({16'(fb + w), 16'(wb + n * WORDS + w)});
    bi = 0;
    bq = -128;
    for (int n = 0; n < N_OUT; n++) begin
      q = quant(res[n]);
      if (q > bq) begin bq = q; bi = n; end
    end
    exp_idx = bi;
    exp_val = bq;
    for (int l = 0; l < 2; l++) begin
      rd_ptr[l] = 0; clr_cnt[l] = 0; last_cnt[l] = 0; en_cnt[l] = 0; mac_k[l] = 0;
      cls_pend[l] = 1'b1;
    end
  endtask

  task automatic launch(input logic [15:0] fb, input logic [15:0] wb, input bit poke);
    @(negedge clk);
    fm_base = fb; wt_base = wb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (poke) begin
      @(negedge clk);
      fm_base = ~fb; wt_base = wb + 16'h0777; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic run_layer(input logic [15:0] fb, input logic [15:0] wb, input bit poke);
    int d0, d1;
    d0 = done_cnt[0];
    d1 = done_cnt[1];
    prep_layer(fb, wb);
    launch(fb, wb, poke);
    for (int c = 0; c < 500 && !(done_cnt[0] > d0 && done_cnt[1] > d1); c++) @(negedge clk);
    chk(done_cnt[0] == d0 + 1 && done_cnt[1] == d1 + 1, "layer_done", done_cnt[0] + done_cnt[1], d0 + d1 + 2);
    repeat (2) @(negedge clk);
    for (int l = 0; l < 2; l++)
      chk(!busy[l] && cls_valid[l], "idle_after_done", {busy[l], cls_valid[l]}, 1);
  endtask

  initial begin
    logic [15:0] fb, wb;
    int dsum;
    for (int l = 0; l < 2; l++) begin
      mac_valid[l] = 1'b0; mac_res[l] = '0; done_cnt[l] = 0; hist[l] = '0;
    end
    for (int n = 0; n < N_OUT; n++) res[n] = 0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    for (int l = 0; l < 2; l++) chk(outs(l) == '0, "reset_outputs", outs(l), 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int l = 0; l < 2; l++) chk(outs(l) == '0, "idle_outputs", outs(l), 0);

    res[0] = 2000; res[1] = 5000; res[2] = -3000;
    run_layer(16'h0010, 16'h0100, 1'b0);
    res[0] = 160; res[1] = 160; res[2] = 16;
    run_layer(16'h0020, 16'h0200, 1'b0);
    for (int n = 0; n < N_OUT; n++) res[n] = -4096;
    run_layer(16'h0030, 16'h0300, 1'b0);
    res[0] = 700; res[1] = -50; res[2] = 900;
    run_layer(16'h0040, 16'h0400, 1'b1);

    // Abort a layer while the fast lane sits in WAIT_RES.
    for (int n = 0; n < N_OUT; n++) res[n] = rand_res();
    prep_layer(16'h0050, 16'h0500);
    launch(16'h0050, 16'h0500, 1'b0);
    for (int c = 0; c < 200 && last_cnt[0] == 0; c++) @(negedge clk);
    chk(last_cnt[0] == 1, "reached_wait_res", last_cnt[0], 1);
    dsum = done_cnt[0] + done_cnt[1];
    #2 rst_n = 1'b0;
    #1;
    for (int l = 0; l < 2; l++) chk(outs(l) == '0, "midlayer_reset_outputs", outs(l), 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk(done_cnt[0] + done_cnt[1] == dsum, "no_done_after_reset", done_cnt[0] + done_cnt[1], dsum);
    for (int n = 0; n < N_OUT; n++) res[n] = rand_res();
    run_layer(16'h0060, 16'h0600, 1'b0);

    for (int k = 0; k < 8; k++) begin
      fb = 16'($urandom);
      wb = 16'($urandom);
      if (k == 0) begin fb = 16'hFFFE; wb = 16'hFFF8; end
      for (int n = 0; n < N_OUT; n++) res[n] = rand_res();
      if ($urandom_range(0, 3) == 0) res[2] = res[0];
      run_layer(fb, wb, $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
